// File: rtl/chip_send_arbiter_pkg.sv
// Shared definitions for the chip send arbiter: FSM encoding, widths, log2 helper.
package chip_send_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARB   = 2'b01,
    STALL = 2'b10
  } arb_state_t;

  localparam int STAT_W = 16;

  // Ceiling log2, never less than 1 so single-entry indices still get a bit.
  function automatic int log2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chip_send_arbiter_rr_pick.sv
// Round-robin priority picker: one-hot grant to the first request at or after ptr.
module rr_pick
  import chip_send_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chip_send_arbiter.sv
// Quantum-limited round-robin arbiter feeding the chip send FIFO.
// Optional per-requester transfer counters under CHIP_SEND_ARB_STAT_EN.
module chip_send_arbiter
  import chip_send_arbiter_pkg::*;
#(
  parameter int  FW      = 64,
  parameter int  CONNECT = 2,
  parameter int  QUANTUM = 4,
  localparam int IW      = log2_min1(CONNECT),
  localparam int BW      = log2_min1(QUANTUM) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CONNECT-1:0]    req_valid,
  input  logic [CONNECT*FW-1:0] req_data,
  output logic [CONNECT-1:0]    req_ready,
  input  logic                  send_fifo_full,
  output logic                  data_out_wr,
  output logic [FW+IW-1:0]      data_out
`ifdef CHIP_SEND_ARB_STAT_EN
  ,
  input  logic                      stat_clr,
  output logic [CONNECT*STAT_W-1:0] stat_cnt
`endif
);

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]     burst_cnt, burst_cnt_nxt;
  logic [BW-1:0]     cnt_base, cnt_inc;
  logic              stall_clean;
  logic [CONNECT-1:0] gnt;
  logic [IW-1:0]     win_idx;
  logic [FW-1:0]     win_data;
  logic              any_valid;
  logic              xfer;

  assign any_valid = |req_valid;
  assign xfer      = |(req_valid & req_ready);

  rr_pick #(
    .N  (CONNECT),
    .IW (IW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < CONNECT; i++) begin
      if (gnt[i]) begin
        win_idx  = IW'(i);
        win_data = req_data[i*FW +: FW];
      end
    end
  end

  // rr_ptr doubles as the current owner: a winner other than rr_ptr starts a new burst.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    req_ready     = '0;
    cnt_base      = (win_idx == rr_ptr) ? burst_cnt : '0;
    cnt_inc       = cnt_base + BW'(1);
    case (state)
      IDLE: begin
        if (send_fifo_full)  state_nxt = STALL;
        else if (any_valid)  state_nxt = ARB;
      end
      ARB: begin
        if (send_fifo_full) begin
          state_nxt = STALL;
        end else if (!any_valid) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end else begin
          req_ready = gnt;
          if (cnt_inc >= BW'(QUANTUM)) begin
            rr_ptr_nxt    = (win_idx == IW'(CONNECT - 1)) ? '0 : win_idx + IW'(1);
            burst_cnt_nxt = '0;
          end else begin
            rr_ptr_nxt    = win_idx;
            burst_cnt_nxt = cnt_inc;
          end
        end
      end
      STALL: begin
        if (!send_fifo_full && stall_clean)
          state_nxt = any_valid ? ARB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      stall_clean <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      burst_cnt   <= burst_cnt_nxt;
      stall_clean <= (state == STALL) && !send_fifo_full;
    end
  end

  // A flit accepted just before almost-full rises is still written; the FIFO margin covers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_wr <= 1'b0;
      data_out    <= '0;
    end else begin
      data_out_wr <= xfer;
      if (xfer) data_out <= {win_idx, win_data};
    end
  end

`ifdef CHIP_SEND_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (stat_clr) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < CONNECT; i++) begin
        if (req_valid[i] && req_ready[i] && (stat_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
          stat_cnt[i*STAT_W +: STAT_W] <= stat_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_chip_send_arbiter.sv
// Scoreboard bench for chip_send_arbiter: directed grant sequences, stall, reset, stats.
module tb_chip_send_arbiter;

  localparam int FW      = 64;
  localparam int CONNECT = 2;
  localparam int QUANTUM = 4;
  localparam int DW      = FW + 1;
  localparam logic [FW-1:0] P0 = 64'h5A5A_0000_C0DE_0001;
  localparam logic [FW-1:0] P1 = 64'h0000_0000_0000_00A5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CONNECT-1:0]    req_valid;
  logic [CONNECT*FW-1:0] req_data;
  logic [CONNECT-1:0]    req_ready;
  logic                  send_fifo_full;
  logic                  data_out_wr;
  logic [DW-1:0]         data_out;
`ifdef CHIP_SEND_ARB_STAT_EN
  logic                  stat_clr;
  logic [CONNECT*16-1:0] stat_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  int seq_rr[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  always #5 clk = ~clk;

  chip_send_arbiter #(
    .FW      (FW),
    .CONNECT (CONNECT),
    .QUANTUM (QUANTUM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .send_fifo_full (send_fifo_full),
    .data_out_wr    (data_out_wr),
    .data_out       (data_out)
`ifdef CHIP_SEND_ARB_STAT_EN
    ,
    .stat_clr       (stat_clr),
    .stat_cnt       (stat_cnt)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] flit(input int idx);
    return (idx == 0) ? {1'b0, P0} : {1'b1, P1};
  endfunction

  // Called at a negedge: the grant expected this cycle and the flit it will produce.
  task automatic expect_xfer(input int idx);
    chk("grant", 128'(req_ready), 128'(1) << idx);
    exp_q.push_back(flit(idx));
  endtask

  task automatic wait_grant(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req_ready != '0) return;
    end
    n_checks++;
    $display("FAIL grant_timeout: got no grant within %0d cycles required a grant", budget);
  endtask

  task automatic drive_next();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && data_out_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL write_unexpected: got data_out %0h required no write", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("data_out", 128'(data_out), 128'(mon_exp));
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    req_valid      = '0;
    req_data       = {P1, P0};
    send_fifo_full = 1'b0;
`ifdef CHIP_SEND_ARB_STAT_EN
    stat_clr       = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_wr", 128'(data_out_wr), 128'(0));
    chk("rst_data", 128'(data_out), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    drive_next();
    rst_n = 1'b1;

    // Both requesters valid: four-flit bursts alternate.
    drive_next();
    req_valid = 2'b11;
    wait_grant(10);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      expect_xfer(seq_rr[k]);
    end
    drive_next();
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Owner 0 drops after two flits: requester 1 takes over with no bubble.
    drive_next();
    req_valid = 2'b11;
    wait_grant(10);
    expect_xfer(0);
    @(negedge clk);
    expect_xfer(0);
    drive_next();
    req_valid = 2'b10;
    @(negedge clk);
    expect_xfer(1);
    @(negedge clk);
    expect_xfer(1);
    @(negedge clk);
    expect_xfer(1);
    drive_next();
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Single flit on requester 1, written one cycle after acceptance.
    drive_next();
    req_valid = 2'b10;
    wait_grant(10);
    expect_xfer(1);
    drive_next();
    req_valid = 2'b00;
    @(negedge clk);
    chk("latency_wr", 128'(data_out_wr), 128'(1));
    chk("latency_data", 128'(data_out), {63'b0, 1'b1, 64'hA5});
    repeat (3) @(negedge clk);

    // Almost-full for five cycles in the middle of requester 1's burst.
    drive_next();
    req_valid = 2'b11;
    wait_grant(10);
    expect_xfer(1);
    @(negedge clk);
    expect_xfer(1);
    drive_next();
    send_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", 128'(req_ready), 128'(0));
      if (k < 4) drive_next();
    end
    drive_next();
    send_fifo_full = 1'b0;
    @(negedge clk);
    chk("stall_exit0", 128'(req_ready), 128'(0));
    @(negedge clk);
    chk("stall_exit1", 128'(req_ready), 128'(0));
    @(negedge clk);
    expect_xfer(1);
    @(negedge clk);
    expect_xfer(1);
    @(negedge clk);
    expect_xfer(0);
    drive_next();
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset while a flit is registered: it is dropped and the pointer returns to 0.
    drive_next();
    req_valid = 2'b10;
    wait_grant(10);
    chk("pre_rst_grant", 128'(req_ready), 128'(2'b10));
    drive_next();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("midrst_wr", 128'(data_out_wr), 128'(0));
    chk("midrst_ready", 128'(req_ready), 128'(0));
    chk("midrst_data", 128'(data_out), 128'(0));
    repeat (2) drive_next();
    rst_n = 1'b1;
    wait_grant(10);
    expect_xfer(0);
    drive_next();
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

`ifdef CHIP_SEND_ARB_STAT_EN
    // Saturating transfer counter on requester 0, then a synchronous clear.
    drive_next();
    req_valid = 2'b01;
    wait_grant(10);
    for (int k = 0; k < 70000; k++) begin
      if (k > 0) @(negedge clk);
      expect_xfer(0);
    end
    drive_next();
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    chk("stat0_sat", 128'(stat_cnt[15:0]), 128'(16'hFFFF));
    chk("stat1_zero", 128'(stat_cnt[31:16]), 128'(0));
    drive_next();
    stat_clr = 1'b1;
    drive_next();
    stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_clr", 128'(stat_cnt), 128'(0));
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chip_send_arbiter.md
CHIP_SEND_ARBITER -- requirements
Module: chip_send_arbiter

Interface
REQ-001 SHALL have parameter FW, default 64: flit payload width in bits.
REQ-002 SHALL have parameter CONNECT, default 2: number of requesters (chip links); IW = log2(CONNECT), minimum 1.
REQ-003 SHALL have parameter QUANTUM, default 4: maximum consecutive transfers granted to one requester.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, CONNECT bits: per-requester flit valid.
REQ-007 SHALL have port req_data, input, CONNECT*FW bits: requester i occupies bits [i*FW +: FW].
REQ-008 SHALL have port req_ready, output, CONNECT bits: per-requester accept, one-hot or zero.
REQ-009 SHALL have port send_fifo_full, input, 1 bit: almost-full from the send FIFO.
REQ-010 SHALL have port data_out_wr, output, 1 bit: send FIFO write strobe.
REQ-011 SHALL have port data_out, output, FW+IW bits: {requester index, payload}.

Function
REQ-012 SHALL run an FSM with three states: IDLE, ARB and STALL.
REQ-013 IDLE: SHALL go to ARB when any req_valid=1 and send_fifo_full=0, and to STALL when send_fifo_full=1.
REQ-014 ARB: SHALL select the winner as the first valid requester, scanning round-robin from rr_ptr.
REQ-015 In ARB, req_ready[winner] SHALL be 1 combinationally in the same cycle; a transfer occurs when valid and ready are both 1.
REQ-016 SHALL register each transfer and present it one cycle later: data_out_wr=1, data_out={winner index, payload}.
REQ-017 Grant hold: the current owner SHALL keep the grant while its valid=1 and burst_cnt<QUANTUM.
REQ-018 On a QUANTUM-th consecutive transfer, or when the owner drops valid, rr_ptr SHALL become (owner+1) mod CONNECT and burst_cnt SHALL clear.
REQ-019 burst_cnt SHALL be a log2(QUANTUM)+1-bit counter, incremented per transfer and never wrapping.
REQ-020 When send_fifo_full=1 in ARB: req_ready SHALL be all 0 in that cycle and the FSM SHALL go to STALL.
REQ-021 A transfer accepted in the cycle before send_fifo_full rises SHALL still be written; the FIFO almost-full margin absorbs it.
REQ-022 STALL SHALL exit to ARB only after send_fifo_full=0 for 2 consecutive cycles, or to IDLE if no valid remains.
REQ-023 While in STALL, rr_ptr and burst_cnt SHALL be held.
REQ-024 ARB SHALL go to IDLE when no req_valid=1; burst_cnt SHALL clear and rr_ptr SHALL be held.
REQ-025 Sustained throughput SHALL be one flit per cycle while any valid=1 and send_fifo_full=0.
REQ-026 A requester whose valid is held at 1 SHALL be granted within (CONNECT-1)*QUANTUM transfers.

Reset
REQ-027 On rst_n low, the FSM SHALL enter IDLE; rr_ptr=0, burst_cnt=0, data_out_wr=0, data_out=0, and req_ready SHALL be all 0.
REQ-028 A reset asserted mid-burst SHALL drop the registered flit, which is not written.

Configuration
REQ-029 With CHIP_SEND_ARB_STAT_EN defined, the block SHALL add port stat_clr (input, 1 bit) and port stat_cnt (output, CONNECT*16 bits).
REQ-030 Each stat_cnt counter SHALL count transfers for its requester, saturate at 16'hFFFF, and reset to 0; stat_clr=1 SHALL clear all counters synchronously.
REQ-031 When stat_clr=1 and a transfer occur in the same cycle, the counter SHALL read 0 on the next cycle.
REQ-032 Without CHIP_SEND_ARB_STAT_EN, neither port nor any counter logic SHALL exist.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding (IDLE=2'b00, ARB=2'b01, STALL=2'b10) and the log2 function.
REQ-034 The round-robin priority picker SHALL be a sub-module, rr_pick: inputs are the request vector and the pointer, output is the one-hot grant.

Verification
REQ-035 CONNECT=2, QUANTUM=4, both valid continuously, FIFO not full -> data_out index sequence 0,0,0,0,1,1,1,1,0.
REQ-036 Only requester 1 valid, payload 64'hA5 -> data_out_wr one cycle after the transfer, data_out={1'b1,64'hA5}.
REQ-037 send_fifo_full=1 for 5 cycles mid-burst -> req_ready=0 throughout, then resumption 2 cycles after full falls, with the same owner and burst_cnt preserved.
REQ-038 rst_n pulsed low during a burst -> data_out_wr=0 immediately, and the next grant goes to requester 0.
REQ-039 CHIP_SEND_ARB_STAT_EN defined, 70000 transfers on requester 0 -> stat_cnt[15:0]=16'hFFFF; stat_clr pulse -> 0.
REQ-040 Owner 0 drops valid after 2 transfers while requester 1 is valid -> grant passes to requester 1 on the next cycle with no bubble.
